pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencing unit for the five-stage MIPS pipeline. Generates the per-cycle enable and flush controls for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB latches from these inputs:
- memory hit signals;
- load-use hazard detection;
- branch/jump redirects;
- halt.

It freezes the whole pipeline while a data access is outstanding and inserts bubbles on hazards. It latches a sticky halt once the halting instruction reaches MEM.

## Interface
Parameters:
- REGW, 5, register-select width.
- CNTW, 32, performance counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- mem_dREN, mem_dWEN  in  1 each  load/store present in MEM stage.
- mem_halt  in  1  HALT instruction present in MEM stage.
- mem_br_taken  in  1  branch resolved taken in MEM.
- id_jump  in  1  J/JAL/JR decoded in ID.
- ex_memtoreg  in  1  load present in EX.
- ex_wsel  in  REGW  EX-stage destination register.
- id_rs, id_rt  in  REGW each  ID-stage source registers.
- id_uses_rt  in  1  ID instruction reads rt.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (NOP, control zero) instead of the input.
- dstall  out  1  high while in DWAIT.
- halt  out  1  sticky halt.
- cyc_cnt, stall_cnt, bubble_cnt  out  CNTW each  performance counters (see Configuration).

## Operation
States: RUN, DWAIT, HALT.

Reset state: RUN. All enables, flushes, dstall, halt and counters are 0.

Derived terms:
- dpend = mem_dREN | mem_dWEN.
- adv = dpend ? dhit : ihit. adv is forced to 0 in HALT.
- lu = ex_memtoreg & (ex_wsel != 0) & ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt))).

Control rules:
- adv = 0: all enables and flushes are 0 (full freeze).
- adv = 1: idex_en = exmem_en = memwb_en = 1. The front end is then chosen by the first matching rule, highest priority first:
  1. mem_br_taken: pc_en = 1, ifid_en = 1 with ifid_flush, idex_flush, exmem_flush all = 1.
  2. dpend: pc_en = 0, ifid_en = 1 with ifid_flush = 1. Memory served data, so no fetch occurred and a bubble enters ID.
  3. lu: pc_en = 0, ifid_en = 0, idex_flush = 1.
  4. id_jump: pc_en = 1, ifid_en = 1 with ifid_flush = 1.
  5. Otherwise: pc_en = ifid_en = 1, no flush.
- A flush is only asserted together with its stage enable.

State transitions:
- RUN → DWAIT when dpend & !dhit.
- DWAIT → RUN on dhit.
- RUN or DWAIT → HALT when mem_halt & adv.
- HALT is left only by reset.

halt output:
- Asserted from the cycle after HALT is entered.
- In HALT all enables are 0.

## Timing
- All control outputs are combinational from the inputs and the current state; there is no added latency.
- halt, dstall and the counters are registered.
- Simultaneous mem_br_taken and lu: the branch wins and the load-use bubble is discarded, because the flushed ID instruction is squashed.
- mem_br_taken while adv = 0: ignored until the adv cycle. The redirect is applied exactly once.
- Back-to-back loads: each remains in DWAIT until its own dhit. A zero-cycle dhit (same cycle) never enters DWAIT.
- ex_wsel = 0 never causes a load-use stall.
- Reset mid-DWAIT or in HALT: immediate return to RUN with all outputs at their reset values.

## Configuration
- PIPE_PERF_EN defined:
  - cyc_cnt increments every cycle outside HALT.
  - stall_cnt increments every cycle with adv = 0 outside HALT.
  - bubble_cnt increments each adv cycle in which any flush is asserted, or in which the lu stall fires.
  - All counters wrap modulo 2^CNTW and freeze in HALT.
- PIPE_PERF_EN undefined: the counter outputs are tied to 0 and no counter flops exist.

## Test plan
- Load in MEM with dhit arriving 3 cycles later → dstall = 1 for 3 cycles with all enables 0. Then one cycle with pc_en = 0, ifid_flush = 1, back-end enables 1; state returns to RUN.
- ex_memtoreg = 1, ex_wsel = 8, id_rs = 8, ihit = 1 → pc_en = 0, ifid_en = 0, idex_flush = 1. The next cycle, with ex_memtoreg = 0, is a normal advance. Repeat with ex_wsel = 0 → no stall.
- mem_br_taken = 1 together with lu = 1 and id_jump = 1 → ifid/idex/exmem flush all 1, pc_en = 1, no load-use hold.
- id_jump = 1, ihit = 1 → pc_en = 1, ifid_flush = 1, idex_flush = 0.
- mem_halt = 1 with ihit = 1 → halt = 1 the next cycle, all enables 0 thereafter regardless of ihit/dhit. nRST pulse → RUN, halt = 0.
- With PIPE_PERF_EN: 10 cycles of ihit = 0 after reset → cyc_cnt = 10, stall_cnt = 10, bubble_cnt = 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Sequencing unit for the five-stage MIPS pipeline. It generates the
// per-cycle load enables and bubble (flush) controls for the PC and the
// IF_ID, ID_EX, EX_MEM and MEM_WB latches. It freezes everything while a
// data access is outstanding, and inserts bubbles for load-use hazards and
// redirects. A halt becomes sticky once HALT reaches MEM and the pipeline
// advances.
//
// Optional feature macro: PIPE_PERF_EN
//   When it is defined, the cycle, stall and bubble performance counters
//   are implemented. When it is undefined, the counter outputs are tied to
//   0 and no counter flops exist.
//
// Ports
//   CLK, nRST                    clock and asynchronous active-low reset
//   ihit, dhit                   instruction fetch / data access completed
//   mem_dREN, mem_dWEN           load/store present in MEM
//   mem_halt                     HALT present in MEM
//   mem_br_taken                 branch resolved taken in MEM
//   id_jump                      J/JAL/JR decoded in ID
//   ex_memtoreg, ex_wsel         load in EX and its destination register
//   id_rs, id_rt, id_uses_rt     ID source registers and rt usage
//   pc_en .. memwb_en            stage load enables (combinational)
//   ifid/idex/exmem_flush        load a bubble instead of the input
//   dstall                       high while waiting on data memory
//   halt                         sticky halt
//   cyc_cnt, stall_cnt, bubble_cnt  performance counters
module pipeline_ctrl #(
   parameter int REGW = 5,
   parameter int CNTW = 32
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            mem_dREN,
   input  logic            mem_dWEN,
   input  logic            mem_halt,
   input  logic            mem_br_taken,
   input  logic            id_jump,
   input  logic            ex_memtoreg,
   input  logic [REGW-1:0] ex_wsel,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic            id_uses_rt,
   output logic            pc_en,
   output logic            ifid_en,
   output logic            idex_en,
   output logic            exmem_en,
   output logic            memwb_en,
   output logic            ifid_flush,
   output logic            idex_flush,
   output logic            exmem_flush,
   output logic            dstall,
   output logic            halt,
   output logic [CNTW-1:0] cyc_cnt,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] bubble_cnt
);

   typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

   state_t state;
   state_t state_next;

   logic dpend;
   logic adv;
   logic lu;
   logic any_flush;

   // Hazard and advance terms
   always_comb begin
      dpend = mem_dREN | mem_dWEN;
      // When a data access is pending, the memory port serves data, so the
      // pipeline advances on dhit rather than ihit.
      adv   = (state != HALT) & (dpend ? dhit : ihit);
      lu    = ex_memtoreg & (ex_wsel != '0) &
              ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
   end

   // Stage enables and flushes. These are combinational so that they take
   // effect in the same cycle as their inputs.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (adv) begin
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
         if (mem_br_taken) begin
            // A taken branch squashes everything younger than MEM. The
            // squash includes any load-use victim in ID.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (dpend) begin
            // The memory port carried data this cycle, so no instruction
            // was fetched. A bubble goes into ID and the PC holds.
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
         end else if (lu) begin
            // Hold PC and IF_ID, and send a bubble into EX.
            idex_flush = 1'b1;
         end else if (id_jump) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
         end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
         end
      end
   end

   assign any_flush = ifid_flush | idex_flush | exmem_flush;

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (mem_halt & adv)
               state_next = HALT;
            else if (dpend & ~dhit)
               state_next = DWAIT;
         end
         DWAIT: begin
            if (mem_halt & adv)
               state_next = HALT;
            else if (dhit)
               state_next = RUN;
         end
         HALT:    state_next = HALT;
         default: state_next = RUN;
      endcase
   end

   // State register. dstall and halt are registered views of the next state,
   // so each is valid for exactly the cycles spent in DWAIT or HALT.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= RUN;
         dstall <= 1'b0;
         halt   <= 1'b0;
      end else begin
         state  <= state_next;
         dstall <= (state_next == DWAIT);
         halt   <= (state_next == HALT);
      end
   end

`ifdef PIPE_PERF_EN
   // Performance counters. They wrap naturally and freeze once halted.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cyc_cnt    <= '0;
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (state != HALT) begin
         cyc_cnt <= cyc_cnt + 1'b1;
         if (!adv)
            stall_cnt <= stall_cnt + 1'b1;
         // Every load-use stall raises idex_flush, so any_flush covers it.
         if (adv & any_flush)
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`else
   assign cyc_cnt    = '0;
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;

   logic unused_flush;
   assign unused_flush = any_flush;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl. It applies a table of single-cycle vectors
// from the RUN state, then directed sequences for DWAIT, halt, reset and
// the performance counters.
module tb_pipeline_ctrl;

   localparam int REGW = 5;
   localparam int CNTW = 32;

   logic            CLK = 1'b0;
   logic            nRST;
   logic            ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_br_taken;
   logic            id_jump, ex_memtoreg, id_uses_rt;
   logic [REGW-1:0] ex_wsel, id_rs, id_rt;
   logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic            ifid_flush, idex_flush, exmem_flush, dstall, halt;
   logic [CNTW-1:0] cyc_cnt, stall_cnt, bubble_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
      .mem_br_taken(mem_br_taken), .id_jump(id_jump),
      .ex_memtoreg(ex_memtoreg), .ex_wsel(ex_wsel), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .dstall(dstall), .halt(halt),
      .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   // Control word: {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}
   localparam logic [7:0] C_FREEZE = 8'b00000_000;
   localparam logic [7:0] C_NORMAL = 8'b11111_000;
   localparam logic [7:0] C_LU     = 8'b00111_010;
   localparam logic [7:0] C_JUMP   = 8'b11111_100;
   localparam logic [7:0] C_BRANCH = 8'b11111_111;
   localparam logic [7:0] C_DATA   = 8'b01111_100;

   typedef struct {
      string           name;
      logic            ihit, dhit, dren, dwen, br, jump, m2r;
      logic [REGW-1:0] wsel, rs, rt;
      logic            uses_rt;
      logic [7:0]      exp;
   } vec_t;

   vec_t vecs[15];

   function automatic logic [7:0] ctl();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_halt = 0;
      mem_br_taken = 0; id_jump = 0; ex_memtoreg = 0; id_uses_rt = 0;
      ex_wsel = '0; id_rs = '0; id_rt = '0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      clear_inputs();
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      //                name            ih dh rd wr br jp m2r wsel rs rt urt exp
      vecs[0]  = '{"idle_no_ihit",   0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, C_FREEZE};
      vecs[1]  = '{"normal",         1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1, C_NORMAL};
      vecs[2]  = '{"lu_rs",          1, 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, C_LU};
      vecs[3]  = '{"lu_after",       1, 0, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd3, 0, C_NORMAL};
      vecs[4]  = '{"lu_wsel0",       1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, C_NORMAL};
      vecs[5]  = '{"lu_rt",          1, 0, 0, 0, 0, 0, 1, 5'd9, 5'd4, 5'd9, 1, C_LU};
      vecs[6]  = '{"rt_unused",      1, 0, 0, 0, 0, 0, 1, 5'd9, 5'd4, 5'd9, 0, C_NORMAL};
      vecs[7]  = '{"jump",           1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, C_JUMP};
      vecs[8]  = '{"br_lu_jump",     1, 0, 0, 0, 1, 1, 1, 5'd8, 5'd8, 5'd0, 0, C_BRANCH};
      vecs[9]  = '{"load_hit0",      0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, C_DATA};
      vecs[10] = '{"store_hit_lu",   1, 1, 0, 1, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, C_DATA};
      vecs[11] = '{"br_no_adv",      0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, C_FREEZE};
      vecs[12] = '{"br_with_data",   0, 1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, C_BRANCH};
      vecs[13] = '{"jump_lu",        1, 0, 0, 0, 0, 1, 1, 5'd6, 5'd6, 5'd0, 0, C_LU};
      vecs[14] = '{"dpend_ihit_ign", 1, 1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, C_DATA};

      nRST = 1'b0;
      clear_inputs();

      // Reset state
      @(negedge CLK);
      #1;
      chk("reset_ctl", 32'(ctl()), 32'(C_FREEZE));
      chk("reset_halt", 32'(halt), 32'd0);
      chk("reset_dstall", 32'(dstall), 32'd0);
      chk("reset_cyc", cyc_cnt, 32'd0);
      chk("reset_stall", stall_cnt, 32'd0);
      chk("reset_bubble", bubble_cnt, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // Table vectors: none of them leaves RUN
      for (int i = 0; i < 15; i++) begin
         @(negedge CLK);
         chk({vecs[i].name, "_dstall_pre"}, 32'(dstall), 32'd0);
         ihit = vecs[i].ihit; dhit = vecs[i].dhit;
         mem_dREN = vecs[i].dren; mem_dWEN = vecs[i].dwen;
         mem_br_taken = vecs[i].br; id_jump = vecs[i].jump;
         ex_memtoreg = vecs[i].m2r; ex_wsel = vecs[i].wsel;
         id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
         mem_halt = 1'b0;
         #1;
         chk(vecs[i].name, 32'(ctl()), 32'(vecs[i].exp));
      end
      @(negedge CLK);
      clear_inputs();
      chk("table_end_halt", 32'(halt), 32'd0);

      // Load with a late dhit, then a normal advance
      ihit = 1; mem_dREN = 1; dhit = 0;
      #1;
      chk("dmiss_ctl", 32'(ctl()), 32'(C_FREEZE));
      chk("dmiss_dstall", 32'(dstall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         #1;
         chk("dwait_dstall", 32'(dstall), 32'd1);
         chk("dwait_ctl", 32'(ctl()), 32'(C_FREEZE));
      end
      @(negedge CLK);
      dhit = 1;
      #1;
      chk("dwait_hit_ctl", 32'(ctl()), 32'(C_DATA));
      @(negedge CLK);
      clear_inputs();
      ihit = 1;
      #1;
      chk("dwait_exit_dstall", 32'(dstall), 32'd0);
      chk("dwait_exit_ctl", 32'(ctl()), 32'(C_NORMAL));

      // Back-to-back accesses, each waiting for its own dhit
      @(negedge CLK);
      mem_dWEN = 1; dhit = 0;
      #1;
      chk("b2b1_ctl", 32'(ctl()), 32'(C_FREEZE));
      @(negedge CLK);
      chk("b2b1_dstall", 32'(dstall), 32'd1);
      dhit = 1;
      #1;
      chk("b2b1_hit", 32'(ctl()), 32'(C_DATA));
      @(negedge CLK);
      mem_dWEN = 0; mem_dREN = 1; dhit = 0;
      #1;
      chk("b2b2_dstall0", 32'(dstall), 32'd0);
      chk("b2b2_ctl", 32'(ctl()), 32'(C_FREEZE));
      @(negedge CLK);
      chk("b2b2_dstall1", 32'(dstall), 32'd1);
      dhit = 1;
      #1;
      chk("b2b2_hit", 32'(ctl()), 32'(C_DATA));
      @(negedge CLK);
      clear_inputs();
      #1;
      chk("b2b_done_dstall", 32'(dstall), 32'd0);

      // A branch during a freeze is held until the advance cycle
      mem_dREN = 1; mem_br_taken = 1;
      @(negedge CLK);
      #1;
      chk("br_frozen_ctl", 32'(ctl()), 32'(C_FREEZE));
      dhit = 1;
      #1;
      chk("br_release_ctl", 32'(ctl()), 32'(C_BRANCH));
      @(negedge CLK);
      clear_inputs();

      // mem_halt without adv does not halt
      mem_halt = 1; ihit = 0;
      @(negedge CLK);
      chk("halt_noadv", 32'(halt), 32'd0);
      ihit = 1;
      #1;
      chk("halt_cycle_ctl", 32'(ctl()), 32'(C_NORMAL));
      @(negedge CLK);
      clear_inputs();
      chk("halt_set", 32'(halt), 32'd1);
      for (int i = 0; i < 3; i++) begin
         ihit = 1; dhit = 1; mem_dREN = 1'(i); mem_br_taken = 1;
         #1;
         chk("halt_ctl", 32'(ctl()), 32'(C_FREEZE));
         @(negedge CLK);
         chk("halt_sticky", 32'(halt), 32'd1);
      end
      clear_inputs();
      ihit = 1;
      #1;
      nRST = 1'b0;
      #1;
      chk("halt_rst_halt", 32'(halt), 32'd0);
      chk("halt_rst_ctl", 32'(ctl()), 32'(C_NORMAL));
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      chk("after_halt_rst", 32'(halt), 32'd0);

      // Reset in the middle of DWAIT
      mem_dREN = 1; dhit = 0;
      @(negedge CLK);
      chk("mid_dwait_dstall", 32'(dstall), 32'd1);
      #1;
      nRST = 1'b0;
      #1;
      chk("mid_dwait_rst_dstall", 32'(dstall), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      clear_inputs();
      ihit = 1;
      #1;
      chk("mid_dwait_run_ctl", 32'(ctl()), 32'(C_NORMAL));
      @(negedge CLK);
      chk("mid_dwait_run_dstall", 32'(dstall), 32'd0);

`ifdef PIPE_PERF_EN
      do_reset();
      repeat (10) @(negedge CLK);
      chk("perf_cyc10", cyc_cnt, 32'd10);
      chk("perf_stall10", stall_cnt, 32'd10);
      chk("perf_bubble0", bubble_cnt, 32'd0);
      ihit = 1; id_jump = 1;
      @(negedge CLK);
      ihit = 1; id_jump = 0; ex_memtoreg = 1; ex_wsel = 5'd3; id_rs = 5'd3;
      @(negedge CLK);
      clear_inputs();
      ihit = 1;
      @(negedge CLK);
      chk("perf_cyc13", cyc_cnt, 32'd13);
      chk("perf_stall_hold", stall_cnt, 32'd10);
      chk("perf_bubble2", bubble_cnt, 32'd2);
      mem_halt = 1;
      @(negedge CLK);
      clear_inputs();
      repeat (3) @(negedge CLK);
      chk("perf_halt_cyc", cyc_cnt, 32'd14);
      chk("perf_halt_stall", stall_cnt, 32'd10);
`else
      do_reset();
      repeat (4) @(negedge CLK);
      chk("noperf_cyc", cyc_cnt, 32'd0);
      chk("noperf_stall", stall_cnt, 32'd0);
      chk("noperf_bubble", bubble_cnt, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
